spi_deserializer: RTL and testbench
===================================

# spi_deserializer

Receive end of the SPI link that the FIFO-side serializer drives. The block oversamples `sclk`, `mosi` and `cs_n` on the system clock and assembles `DATAWIDTH`-bit words, MSB first. It writes each completed word into the receive FIFO through a single-cycle write strobe. Frame-level errors are flagged: a word that arrives while the FIFO is full, or a select deasserted mid-word.

## Interface
Reset is synchronous, active-high; all state changes on `posedge clk`.

Parameters:
- `DATAWIDTH`, 32: bits per word.
- `BITCOUNTERWIDTH`, `$clog2(DATAWIDTH)`: bit counter is `BITCOUNTERWIDTH+1` bits and holds 0..`DATAWIDTH`.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: serial clock, asynchronous to `clk`.
- `mosi` input 1: serial data, asynchronous to `clk`.
- `cs_n` input 1: active-low frame select, asynchronous to `clk`.
- `full` input 1: receive FIFO full.
- `writeEnable` output 1: one-cycle write strobe to the FIFO.
- `writeData` output `DATAWIDTH`: word to write; valid while `writeEnable` is high.
- `overflow` output 1: one-cycle pulse when a completed word is dropped because `full` is high.
- `frame_error` output 1: one-cycle pulse when `cs_n` rises with a partial word.
- `busy` output 1: high while in RECEIVE or STORE.

## Operation
- `sclk`, `mosi` and `cs_n` each pass through a 2-flop synchronizer.
- `sclk` and `cs_n` get a third register for edge detection:
  - `rise` = s2 & ~s3.
  - `cs_fall` / `cs_rise` are defined the same way.
- States:
  - IDLE: counter and shift register cleared. `cs_fall`, or synchronized `cs_n` low, → RECEIVE.
  - RECEIVE: on `rise`, shift left and insert synchronized `mosi` at the LSB; counter +1. If the counter reaches `DATAWIDTH` on that edge → STORE. On `cs_rise` with the counter at 1..`DATAWIDTH`-1 → pulse `frame_error`, discard, → IDLE. `cs_rise` with the counter at 0 → IDLE silently.
  - STORE, one cycle:
    - If `full` is low: `writeEnable`=1 and `writeData` = the assembled word.
    - Else: `overflow`=1 and the word is discarded.
    - Counter cleared.
    - Next state is RECEIVE if synchronized `cs_n` is low, else IDLE. Back-to-back words within one frame are supported.
- A word completing in the same cycle as `cs_rise` goes to STORE. The word is stored, with no `frame_error`, then → IDLE.
- `full` is sampled only in STORE. Its value at any other time has no effect.
- `rst` mid-frame clears everything and discards the partial word. There is no `frame_error`.

## Timing
- Reset values: `writeEnable`=0, `writeData`=0, `overflow`=0, `frame_error`=0, `busy`=0, state IDLE, synchronizer flops 0. The `cs_n` sync flops reset to 1.
- A pin edge of `sclk` is seen as `rise` 2 clk cycles later.
- The last data bit is sampled in the `rise` cycle. STORE, with its `writeEnable` or `overflow`, follows in the next cycle, i.e. 3 cycles after the pin edge.
- `writeData` holds its value after the strobe until the next store; only `writeEnable` qualifies it.
- Legal input timing:
  - `sclk` high time and low time are each ≥2 `clk` cycles. This matches the serializer's divided clock.
  - `mosi` changes only while `sclk` is high or at its falling edge, and is stable for ≥2 cycles before the rising edge.
  - `cs_n` falls ≥2 cycles before the first `sclk` rise.
- Pulse outputs (`writeEnable`, `overflow`, `frame_error`) are exactly one cycle wide and mutually exclusive in any cycle.

## Structure
- Shared package `spi_pkg`:
  - `rx_state_t` enum (IDLE, RECEIVE, STORE), `logic [1:0]`.
  - Constant `SYNC_STAGES` = 2.
  - Place the serializer's state enum here too.
- One sub-module, `spi_sync_edge`:
  - Parameterized synchronizer with a `RESET_VAL` parameter.
  - Outputs the synchronized level plus `rise` / `fall` pulses.
  - Instantiated for `sclk`, `cs_n` and `mosi`; the `mosi` edge outputs are unused.
- Top module: FSM, shift register, bit counter, output registers.

## Test plan
- Reset then idle: hold `rst` 3 cycles with random pins. Outputs stay 0 and `busy`=0 until `cs_n` falls.
- Single word: frame of 0xA5C3_0F81 at half-period 2 clk, `full`=0. Exactly one `writeEnable`, with `writeData`=0xA5C3_0F81, 3 cycles after the 32nd `sclk` rise. `busy` returns to 0 after `cs_n` rises.
- Back-to-back: 0xDEAD_BEEF then 0x0000_0001 within one `cs_n` low frame. Two strobes carry those values in order, with no `frame_error`.
- Overflow: `full`=1 during STORE for 0x1234_5678. `overflow` pulses once, `writeEnable` stays 0, and the next word 0x8765_4321 (`full`=0) is written correctly.
- Truncated frame: `cs_n` rises after 13 bits. `frame_error` pulses once with no write. The next full frame of 0xFFFF_0000 is written correctly.
- Reset mid-word: assert `rst` after 20 bits. No write or error occurs, and a subsequent frame of 0x0F0F_F0F0 is received intact.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link definitions for the serializer and deserializer blocks.
// Holds the receiver and transmitter state encodings and the synchronizer depth.
package spi_pkg;

    // Number of flops used to bring each asynchronous pin into the clk domain.
    localparam int SYNC_STAGES = 2;

    // Receive-side FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        STORE   = 2'd2
    } rx_state_t;

    // Transmit-side FSM states (used by the FIFO-side serializer).
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous pin.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset; every flop loads RESET_VAL
//   din   - asynchronous input pin
//   level - synchronized level (output of the last synchronizer stage)
//   rise  - one-cycle pulse when the synchronized level goes 0 -> 1
//   fall  - one-cycle pulse when the synchronized level goes 1 -> 0
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0,
    parameter int   STAGES    = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // pipe[STAGES-1] is the synchronized level; pipe[STAGES] is its one-cycle
    // delayed copy used only for edge detection.
    logic [STAGES:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= {(STAGES + 1){RESET_VAL}};
        end else begin
            pipe <= {pipe[STAGES-1:0], din};
        end
    end

    assign level = pipe[STAGES-1];
    assign rise  = pipe[STAGES-1] & ~pipe[STAGES];
    assign fall  = ~pipe[STAGES-1] & pipe[STAGES];

endmodule

// File: rtl/spi_deserializer.sv
// SPI receive end: oversamples sclk/mosi/cs_n on clk, assembles DATAWIDTH-bit
// words MSB first and writes each completed word into the receive FIFO.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   sclk, mosi   - serial clock and data (asynchronous to clk)
//   cs_n         - active-low frame select (asynchronous to clk)
//   full         - receive FIFO full, looked at only in STORE
//   writeEnable  - one-cycle FIFO write strobe
//   writeData    - word being written; holds after the strobe until next store
//   overflow     - one-cycle pulse when a completed word is dropped (full)
//   frame_error  - one-cycle pulse when cs_n rises on a partial word
//   busy         - high while in RECEIVE or STORE
module spi_deserializer
    import spi_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    input  logic                 full,
    output logic                 writeEnable,
    output logic [DATAWIDTH-1:0] writeData,
    output logic                 overflow,
    output logic                 frame_error,
    output logic                 busy
);

    localparam logic [BITCOUNTERWIDTH:0] LAST_BIT = (BITCOUNTERWIDTH + 1)'(DATAWIDTH - 1);

    rx_state_t state, state_next;

    logic                     sclk_rise, unused_sclk_level, unused_sclk_fall;
    logic                     cs_level, cs_rise, cs_fall;
    logic                     mosi_level, unused_mosi_rise, unused_mosi_fall;
    logic [DATAWIDTH-1:0]     shift_reg;
    logic [DATAWIDTH-1:0]     data_hold;
    logic [BITCOUNTERWIDTH:0] bit_cnt;
    logic                     word_done;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (unused_sclk_level),
        .rise  (sclk_rise),
        .fall  (unused_sclk_fall)
    );

    // cs_n idles high, so its flops reset high to avoid a false edge.
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (mosi),
        .level (mosi_level),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    // Last bit of the word is being sampled this cycle. It wins over a
    // simultaneous cs_rise so a word finishing with the frame is still stored.
    assign word_done = (state == RECEIVE) && sclk_rise && (bit_cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cs_fall || !cs_level) state_next = RECEIVE;
            end
            RECEIVE: begin
                if (word_done)    state_next = STORE;
                else if (cs_rise) state_next = IDLE;
            end
            STORE: begin
                state_next = cs_level ? IDLE : RECEIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        writeEnable = 1'b0;
        overflow    = 1'b0;
        frame_error = 1'b0;
        busy        = (state != IDLE);
        writeData   = data_hold;
        unique case (state)
            STORE: begin
                writeEnable = !full;
                overflow    = full;
                writeData   = shift_reg;
            end
            RECEIVE: begin
                // Any bit already counted (or arriving now) makes it a partial word.
                frame_error = cs_rise && !word_done && ((bit_cnt != '0) || sclk_rise);
            end
            default: ;
        endcase
    end

    // Shift register, bit counter and write-data hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            data_hold <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
                RECEIVE: begin
                    if (cs_rise && !word_done) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[DATAWIDTH-2:0], mosi_level};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                STORE: begin
                    // Only a word actually written becomes the held writeData.
                    if (!full) data_hold <= shift_reg;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
                default: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer: directed frames plus randomized
// frames, checked against an expected-event queue built from the bit stream.
module tb_spi_deserializer;

    localparam int EV_WRITE = 0;
    localparam int EV_OVF   = 1;
    localparam int EV_FERR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, mosi, cs_n, full;
    logic        writeEnable, overflow, frame_error, busy;
    logic [31:0] writeData;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_rise_cyc = 0;
    int last_we_cyc   = 0;
    int we_seen = 0, ovf_seen = 0, fe_seen = 0;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    spi_deserializer #(.DATAWIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .full        (full),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .overflow    (overflow),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pops the next expected event and checks it is of the given kind.
    task automatic take_event(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1;
        e.data = '0;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            ok = 1'b1;
        end
    endtask

    // Output monitor, sampled just after each active edge.
    always @(posedge clk) begin
        ev_t e;
        bit  ok;
        int  npulse;
        #1;
        npulse = int'(writeEnable) + int'(overflow) + int'(frame_error);
        if (npulse != 0) chk("pulse_exclusive", 32'(npulse), 32'd1);
        if (writeEnable) begin
            we_seen++;
            last_we_cyc = cyc;
            take_event(EV_WRITE, e, ok);
            if (ok && e.kind == EV_WRITE) chk("write_data", writeData, e.data);
        end
        if (overflow) begin
            ovf_seen++;
            take_event(EV_OVF, e, ok);
        end
        if (frame_error) begin
            fe_seen++;
            take_event(EV_FERR, e, ok);
        end
    end

    task automatic start_frame();
        sclk = 1'b0;
        cs_n = 1'b0;
        wait_cyc(3);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        wait_cyc(2);
        cs_n = 1'b1;
        wait_cyc(5);
    endtask

    // Shifts out the top nbits of w MSB first. A complete word queues its
    // expected write (or overflow when full is held high for the word).
    task automatic send_word(input logic [31:0] w, input int nbits, input logic fullv);
        int  hp;
        ev_t e;
        full = fullv;
        if (nbits == 32) begin
            e.kind = fullv ? EV_OVF : EV_WRITE;
            e.data = w;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            hp   = $urandom_range(2, 4);
            sclk = 1'b0;
            mosi = w[31-i];
            wait_cyc(hp);
            sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_cyc(hp);
        end
        wait_cyc(3);
    endtask

    task automatic expect_ferr();
        ev_t e;
        e.kind = EV_FERR;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    initial begin
        int base_we, base_ovf, base_fe;
        int nw;
        logic [31:0] w;

        // Reset with random pins, then idle pins while still in reset.
        rst = 1'b1;
        sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; full = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'($urandom); mosi = 1'($urandom);
            cs_n = 1'($urandom); full = 1'($urandom);
            @(negedge clk);
            chk("rst_we", {31'd0, writeEnable}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; full = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        chk("idle_we", {31'd0, writeEnable}, 32'd0);
        chk("idle_wdata", writeData, 32'd0);
        chk("idle_ovf", {31'd0, overflow}, 32'd0);
        chk("idle_ferr", {31'd0, frame_error}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single word with latency check.
        base_we = we_seen;
        start_frame();
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        send_word(32'hA5C3_0F81, 32, 1'b0);
        chk("store_latency", 32'(last_we_cyc - last_rise_cyc), 32'd3);
        end_frame();
        chk("single_count", 32'(we_seen - base_we), 32'd1);
        chk("single_busy_off", {31'd0, busy}, 32'd0);
        chk("wdata_holds", writeData, 32'hA5C3_0F81);

        // Back-to-back words in one frame.
        base_we = we_seen; base_fe = fe_seen;
        start_frame();
        send_word(32'hDEAD_BEEF, 32, 1'b0);
        send_word(32'h0000_0001, 32, 1'b0);
        end_frame();
        chk("b2b_count", 32'(we_seen - base_we), 32'd2);
        chk("b2b_no_ferr", 32'(fe_seen - base_fe), 32'd0);

        // Overflow then a normal write.
        base_we = we_seen; base_ovf = ovf_seen;
        start_frame();
        send_word(32'h1234_5678, 32, 1'b1);
        send_word(32'h8765_4321, 32, 1'b0);
        end_frame();
        chk("ovf_count", 32'(ovf_seen - base_ovf), 32'd1);
        chk("ovf_writes", 32'(we_seen - base_we), 32'd1);

        // Truncated frame, then a good one.
        base_we = we_seen; base_fe = fe_seen;
        start_frame();
        send_word(32'h5555_AAAA, 13, 1'b0);
        expect_ferr();
        end_frame();
        chk("trunc_ferr", 32'(fe_seen - base_fe), 32'd1);
        chk("trunc_no_write", 32'(we_seen - base_we), 32'd0);
        start_frame();
        send_word(32'hFFFF_0000, 32, 1'b0);
        end_frame();

        // Reset mid-word: no write, no error, next frame intact.
        base_we = we_seen; base_fe = fe_seen; base_ovf = ovf_seen;
        start_frame();
        send_word(32'h3C3C_9999, 20, 1'b0);
        sclk = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        cs_n = 1'b1;
        wait_cyc(5);
        chk("rstmid_events", 32'((we_seen - base_we) + (fe_seen - base_fe) + (ovf_seen - base_ovf)), 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        start_frame();
        send_word(32'h0F0F_F0F0, 32, 1'b0);
        end_frame();
        chk("directed_pending", 32'(exp_q.size()), 32'd0);

        // Randomized frames: 1..3 words, random full, occasional truncation.
        for (int f = 0; f < 8; f++) begin
            nw = $urandom_range(1, 3);
            start_frame();
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                send_word(w, 32, ($urandom_range(0, 3) == 0));
            end
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                send_word(w, $urandom_range(1, 31), 1'b0);
                expect_ferr();
            end
            end_frame();
            chk("rand_busy_off", {31'd0, busy}, 32'd0);
        end
        full = 1'b0;
        wait_cyc(4);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
